// File: rtl/q_pkg.sv
// q_pkg: shared types and constants for the fixed-point blocks.
//   q_div_state_t : divider FSM states (IDLE/DIV/FIX/DONE)
//   DIV_ITERS     : quotient bits produced by the divider, including one
//                   guard bit used for rounding
// Width and saturation constants come from include.vh.
`include "include.vh"

package q_pkg;

    localparam int unsigned DIV_ITERS = `FIXED_WIDTH + `FRAC_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } q_div_state_t;

endpackage

// File: rtl/include.vh
// Shared fixed-point format definitions for the arithmetic datapath.
// FIXED_WIDTH : total word width (two's complement)
// FRAC_BITS   : fractional bits in the Qm.n format
// FIXED_MAX   : most positive representable value
// FIXED_MIN   : most negative representable value
`ifndef Q_INCLUDE_VH
`define Q_INCLUDE_VH
`define FIXED_WIDTH 16
`define FRAC_BITS 8
`define FIXED_MAX ({1'b0, {(`FIXED_WIDTH-1){1'b1}}})
`define FIXED_MIN ({1'b1, {(`FIXED_WIDTH-1){1'b0}}})
`endif

// File: rtl/q_sat_round.sv
// q_sat_round: combinational round-half-away-from-zero and saturation of an
// unsigned magnitude that carries one guard bit below the result LSB.
// Ports:
//   mag_ext (in,  MAG_W) : magnitude with guard bit in bit 0
//   sign    (in,  1)     : 1 if the result is negative
//   result  (out, OUT_W) : rounded, saturated two's-complement value
//   sat     (out, 1)     : result was clamped to the positive/negative limit
`include "include.vh"

module q_sat_round
    import q_pkg::*;
#(
    parameter int unsigned MAG_W = DIV_ITERS,
    parameter int unsigned OUT_W = `FIXED_WIDTH
) (
    input  logic [MAG_W-1:0]        mag_ext,
    input  logic                    sign,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // Largest magnitudes that still fit for each sign: 2^(W-1)-1 and 2^(W-1).
    localparam logic [MAG_W-1:0] POS_LIM = {{(MAG_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [MAG_W-1:0] NEG_LIM = {{(MAG_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [MAG_W-1:0] rounded;

    always_comb begin
        // (q + 1) >> 1 written as (q >> 1) + guard, which cannot carry out.
        rounded = (mag_ext >> 1) + {{(MAG_W-1){1'b0}}, mag_ext[0]};
        sat     = 1'b0;
        result  = '0;
        if (!sign) begin
            if (rounded > POS_LIM) begin
                sat    = 1'b1;
                result = OUT_MAX;
            end else begin
                result = rounded[OUT_W-1:0];
            end
        end else begin
            if (rounded > NEG_LIM) begin
                sat    = 1'b1;
                result = OUT_MIN;
            end else begin
                // A magnitude of exactly 2^(W-1) negates to FIXED_MIN.
                result = '0 - rounded[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/q_div.sv
// q_div: sequential signed fixed-point divider, result = round(a / b) in the
// shared FIXED_WIDTH/FRAC_BITS format. Radix-2 restoring division on
// magnitudes, then sign fix-up, rounding and saturation.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (a dividend, b divisor)
//   out_valid/out_ready : result handshake
//   result            : rounded, saturated quotient
//   overflow          : quotient saturated with a non-zero divisor
//   div_by_zero       : divisor was zero
// Configuration macro: Q_DIV_ZERO_BYPASS_EN -- when defined, a zero divisor
// skips the DIV iterations and goes straight to FIX (same result and flags).
`include "include.vh"

module q_div
    import q_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [`FIXED_WIDTH-1:0] a,
    input  logic signed [`FIXED_WIDTH-1:0] b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [`FIXED_WIDTH-1:0] result,
    output logic                           overflow,
    output logic                           div_by_zero
);

    localparam int unsigned W  = `FIXED_WIDTH;
    localparam int unsigned F  = `FRAC_BITS;
    localparam int unsigned N  = DIV_ITERS;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  Q_MAX    = `FIXED_MAX;
    localparam logic [W-1:0]  Q_MIN    = `FIXED_MIN;

    q_div_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;   // dividend in, quotient (with guard bit) out
    logic [W-1:0]  babs_q, babs_d;
    logic          sign_q, sign_d;
    logic          zero_q, zero_d;
    logic [W-1:0]  result_q, result_d;
    logic          overflow_q, overflow_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  a_abs, b_abs;
    logic [W:0]    rem_sh;
    logic          rem_ge;
    logic signed [W-1:0] sr_result;
    logic          sr_sat;

    q_sat_round #(
        .MAG_W (N),
        .OUT_W (W)
    ) u_sat_round (
        .mag_ext (dvd_q),
        .sign    (sign_q),
        .result  (sr_result),
        .sat     (sr_sat)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        babs_d      = babs_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        // |FIXED_MIN| = 2^(W-1) fits as an unsigned W-bit magnitude.
        a_abs  = a[W-1] ? ('0 - a) : a;
        b_abs  = b[W-1] ? ('0 - b) : b;
        rem_sh = (rem_q << 1) | {{W{1'b0}}, dvd_q[N-1]};
        rem_ge = (rem_sh >= {1'b0, babs_q});

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = a[W-1] ^ b[W-1];
                    babs_d = b_abs;
                    zero_d = (b == '0);
                    dvd_d  = {a_abs, {(F+1){1'b0}}};
                    rem_d  = '0;
                    cnt_d  = '0;
`ifdef Q_DIV_ZERO_BYPASS_EN
                    state_d = (b == '0) ? FIX : DIV;
`else
                    state_d = DIV;
`endif
                end
            end
            DIV: begin
                rem_d = rem_ge ? (rem_sh - {1'b0, babs_q}) : rem_sh;
                dvd_d = {dvd_q[N-2:0], rem_ge};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    // b == 0, so sign_q is just the sign of a.
                    result_d   = sign_q ? Q_MIN : Q_MAX;
                    overflow_d = 1'b0;
                    dbz_d      = 1'b1;
                end else begin
                    result_d   = sr_result;
                    overflow_d = sr_sat;
                    dbz_d      = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            babs_q      <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            babs_q      <= babs_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
